// File: rtl/char_draw_controller.sv
// Sequences one 5x5 glyph draw: CLEAR, LOAD, PIXELS DRAW cycles, DONE; plot trails enable_counter by one.
// Accept-to-done is 28 cycles at PIXELS=25; ready drops while busy and requests are not queued.
module char_draw_controller #(
   parameter int PIXELS = 25
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req,
   output logic       ready,
   input  logic [7:0] address_in,
   input  logic [8:0] x_pos,
   input  logic [8:0] y_pos,
   input  logic       abort,
   output logic [7:0] address,
   output logic [8:0] x_input,
   output logic [8:0] y_input,
   output logic       reset_counter,
   output logic       ld_value,
   output logic       ld_colour,
   output logic       enable_counter,
   output logic       next_colour,
   output logic       plot,
   output logic       busy,
   output logic       done
);

   typedef enum logic [2:0] {IDLE, CLEAR, LOAD, DRAW, DONE} state_t;

   localparam logic [4:0] LAST_PIX = 5'(PIXELS - 1);

   state_t     state, state_nxt;
   logic [4:0] pix_cnt, pix_cnt_nxt;
   logic       plot_q;
   logic       accept;

   // ready is held low during reset so nothing can be accepted on release
   assign ready  = rst_n & (state == IDLE) & ~abort;
   assign accept = req & ready;

   always_comb begin
      state_nxt   = state;
      pix_cnt_nxt = pix_cnt;
      case (state)
         IDLE:  if (accept) state_nxt = CLEAR;
         CLEAR: state_nxt = LOAD;
         LOAD: begin
            state_nxt   = DRAW;
            pix_cnt_nxt = '0;
         end
         DRAW: begin
            if (pix_cnt == LAST_PIX) begin
               state_nxt   = DONE;
               pix_cnt_nxt = '0;
            end else begin
               pix_cnt_nxt = pix_cnt + 5'd1;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (abort && (state != IDLE)) begin
         state_nxt   = IDLE;
         pix_cnt_nxt = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         pix_cnt <= '0;
         plot_q  <= 1'b0;
         address <= '0;
         x_input <= '0;
         y_input <= '0;
      end else begin
         state   <= state_nxt;
         pix_cnt <= pix_cnt_nxt;
         // an aborted DRAW cycle must not leave a plot behind in the IDLE cycle
         plot_q  <= (state == DRAW) & ~abort;
         if (accept) begin
            address <= address_in;
            x_input <= x_pos;
            y_input <= y_pos;
         end
      end
   end

   assign reset_counter  = (state == CLEAR);
   assign ld_value       = (state == LOAD);
   assign ld_colour      = (state == LOAD);
   assign enable_counter = (state == DRAW);
   assign next_colour    = (state == DRAW);
   assign plot           = plot_q;
   assign busy           = (state != IDLE);
   assign done           = (state == DONE);

endmodule

// File: tb/tb_char_draw_controller.sv
// Randomised bench for char_draw_controller: a draw-level model queues expected plot/done
// events on acceptance; a negedge monitor pops them and checks ready, busy, strobes and held values.
module tb_char_draw_controller;

   logic       clk = 1'b0;
   logic       rst_n, req, abort;
   logic [7:0] address_in;
   logic [8:0] x_pos, y_pos;
   logic       ready;
   logic [7:0] address;
   logic [8:0] x_input, y_input;
   logic       reset_counter, ld_value, ld_colour, enable_counter, next_colour;
   logic       plot, busy, done;

   char_draw_controller #(.PIXELS(25)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .ready(ready),
      .address_in(address_in), .x_pos(x_pos), .y_pos(y_pos), .abort(abort),
      .address(address), .x_input(x_input), .y_input(y_input),
      .reset_counter(reset_counter), .ld_value(ld_value), .ld_colour(ld_colour),
      .enable_counter(enable_counter), .next_colour(next_colour),
      .plot(plot), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   typedef struct {
      int   cyc;
      logic last;
   } ev_t;

   ev_t        exp_q[$];
   int         cyc      = 0;
   int         busy_end = -1;
   int         clr_cyc  = -100;
   logic [7:0] e_addr   = '0;
   logic [8:0] e_x      = '0;
   logic [8:0] e_y      = '0;
   int         n_cmp    = 0;
   int         n_bad    = 0;
   bit         started  = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   // Draw-level model: an accepted draw owns the next 28 cycles and plots on the last 25 of them.
   task automatic model_edge();
      ev_t ev;
      if (rst_n) begin
         if (cyc > busy_end) begin
            if (req && !abort) begin
               clr_cyc  = cyc + 1;
               busy_end = cyc + 28;
               e_addr   = address_in;
               e_x      = x_pos;
               e_y      = y_pos;
               for (int k = 4; k <= 28; k++) begin
                  ev.cyc  = cyc + k;
                  ev.last = (k == 28);
                  exp_q.push_back(ev);
               end
            end
         end else if (abort) begin
            busy_end = cyc;
            while (exp_q.size() > 0 && exp_q[exp_q.size()-1].cyc > cyc)
               void'(exp_q.pop_back());
         end
      end
      cyc++;
   endtask

   task automatic step(input logic r, input logic a, input logic [7:0] ad,
                       input logic [8:0] xx, input logic [8:0] yy);
      req        = r;
      abort      = a;
      address_in = ad;
      x_pos      = xx;
      y_pos      = yy;
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic idle_steps(input int n);
      for (int i = 0; i < n; i++)
         step(1'b0, 1'b0, 8'($urandom), 9'($urandom), 9'($urandom));
   endtask

   task automatic do_reset();
      req   = 1'b0;
      abort = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("async_reset_outputs",
          {ready, busy, done, plot, reset_counter, ld_value, ld_colour,
           enable_counter, next_colour, address, x_input, y_input}, '0);
      exp_q.delete();
      busy_end = -1;
      clr_cyc  = -100;
      e_addr   = '0;
      e_x      = '0;
      e_y      = '0;
      @(posedge clk);
      model_edge();
      @(negedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk);
      model_edge();
      #1;
   endtask

   int   mon_off;
   ev_t  mon_ev;
   logic mon_busy;

   always @(negedge clk) begin
      if (started) begin
         mon_busy = (cyc <= busy_end);
         mon_off  = cyc - clr_cyc;
         chk("ready", ready, (cyc > busy_end) && !abort && rst_n);
         chk("busy", busy, mon_busy);
         chk("strobes", {reset_counter, ld_value, ld_colour, enable_counter, next_colour},
             mon_busy ? {mon_off == 0, mon_off == 1, mon_off == 1,
                         (mon_off >= 2 && mon_off <= 26), (mon_off >= 2 && mon_off <= 26)}
                      : 5'b0);
         chk("held_values", {address, x_input, y_input}, {e_addr, e_x, e_y});
         while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            mon_ev = exp_q.pop_front();
            chk("missing_plot", 1'b0, 1'b1);
         end
         if (plot || done) begin
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
               mon_ev = exp_q.pop_front();
               chk("plot_done", {plot, done}, {1'b1, mon_ev.last});
            end else begin
               chk("unexpected_plot_done", {plot, done}, 2'b00);
            end
         end
      end
   end

   initial begin
      rst_n      = 1'b0;
      req        = 1'b0;
      abort      = 1'b0;
      address_in = '0;
      x_pos      = '0;
      y_pos      = '0;
      #3;
      chk("reset_state",
          {ready, busy, done, plot, reset_counter, ld_value, ld_colour,
           enable_counter, next_colour, address, x_input, y_input}, '0);
      started = 1;
      repeat (2) begin
         @(posedge clk);
         model_edge();
      end
      @(negedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk);
      model_edge();
      #1;

      // single draw, with a rejected request arriving mid-DRAW
      step(1'b1, 1'b0, 8'h1C, 9'd40, 9'd20);
      idle_steps(12);
      step(1'b1, 1'b0, 8'h45, 9'd7, 9'd9);
      idle_steps(20);

      // abort partway through DRAW
      step(1'b1, 1'b0, 8'h2A, 9'd100, 9'd50);
      idle_steps(11);
      step(1'b0, 1'b1, 8'h00, 9'd0, 9'd0);
      idle_steps(4);

      // back-to-back with req held high
      for (int i = 0; i < 60; i++) step(1'b1, 1'b0, 8'h21, 9'd300, 9'd200);
      idle_steps(3);

      // asynchronous reset during LOAD, then a fresh draw
      step(1'b1, 1'b0, 8'h33, 9'd1, 9'd2);
      idle_steps(1);
      do_reset();
      step(1'b1, 1'b0, 8'h5A, 9'd511, 9'd511);
      idle_steps(30);

      // abort and req together in IDLE
      step(1'b1, 1'b1, 8'h77, 9'd3, 9'd4);
      idle_steps(3);

      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 299) == 0)
            do_reset();
         else
            step($urandom_range(0, 3) == 0, $urandom_range(0, 49) == 0,
                 8'($urandom), 9'($urandom), 9'($urandom));
      end
      idle_steps(35);
      chk("events_drained", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
